// File: rtl/seq_unsigned_divider_if.sv
// Handshake/bus bundle for seq_unsigned_divider: operand request and result response.
interface seq_unsigned_divider_if #(
    parameter int unsigned DW = 16,
    parameter int unsigned VW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;
    logic          busy;

    // Producer/consumer side of the divider.
    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero, busy
    );

    // Divider side.
    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero, busy
    );
endinterface

// File: rtl/seq_unsigned_divider.sv
// Sequential restoring unsigned divider, one quotient bit per clock.
// Optional feature macro: DIV_EARLY_EXIT_EN -- when defined, a dividend smaller
// than a nonzero divisor skips the iteration phase (same result, lower latency).
module seq_unsigned_divider #(
    parameter int unsigned DW = 16,
    parameter int unsigned VW = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    seq_unsigned_divider_if.slave  bus
);
    localparam int unsigned CW = $clog2(DW + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t        state;
    state_t        state_nxt;

    logic [DW-1:0] q;
    logic [VW-1:0] d;
    logic [VW:0]   r;
    logic [CW-1:0] cnt;
    logic          dbz;

    logic          in_ready_q;
    logic          out_valid_q;
    logic          busy_q;
    logic          in_ready_nxt;
    logic          out_valid_nxt;
    logic          busy_nxt;

    logic          accept_c;
    logic          drain_c;
    logic          zero_c;
    logic          early_c;
    logic          last_c;
    logic          ge_c;
    logic [VW:0]   t_c;
    logic [VW:0]   diff_c;

    assign accept_c = bus.in_valid & in_ready_q;
    assign drain_c  = out_valid_q & bus.out_ready;
    assign zero_c   = (bus.divisor == '0);
    assign last_c   = (cnt == CW'(1));

`ifdef DIV_EARLY_EXIT_EN
    assign early_c  = (bus.dividend < DW'(bus.divisor));
`else
    assign early_c  = 1'b0;
`endif

    // Partial remainder shifted left with the next dividend bit; VW+1 wide so it cannot overflow.
    assign t_c    = {r[VW-1:0], q[DW-1]};
    assign ge_c   = (t_c >= {1'b0, d});
    assign diff_c = t_c - {1'b0, d};

    // State and registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_nxt;
            in_ready_q  <= in_ready_nxt;
            out_valid_q <= out_valid_nxt;
            busy_q      <= busy_nxt;
        end
    end

    // Next-state decision.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    if (zero_c || early_c) state_nxt = DONE;
                    else                   state_nxt = RUN;
                end
            end
            RUN:     if (last_c)  state_nxt = DONE;
            DONE:    if (drain_c) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode of the upcoming state, registered alongside it.
    always_comb begin
        in_ready_nxt  = 1'b0;
        out_valid_nxt = 1'b0;
        busy_nxt      = 1'b1;
        case (state_nxt)
            IDLE: begin
                in_ready_nxt = 1'b1;
                busy_nxt     = 1'b0;
            end
            DONE:    out_valid_nxt = 1'b1;
            default: ;
        endcase
    end

    // Operand latch, restoring iteration and result hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            q   <= '0;
            d   <= '0;
            r   <= '0;
            cnt <= '0;
            dbz <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        d   <= bus.divisor;
                        cnt <= CW'(DW);
                        if (zero_c) begin
                            q   <= '1;
                            r   <= '0;
                            dbz <= 1'b1;
                        end else if (early_c) begin
                            q   <= '0;
                            r   <= (VW + 1)'(bus.dividend[VW-1:0]);
                        end else begin
                            q   <= bus.dividend;
                            r   <= '0;
                        end
                    end
                end
                RUN: begin
                    q   <= {q[DW-2:0], ge_c};
                    r   <= ge_c ? diff_c : t_c;
                    cnt <= cnt - CW'(1);
                end
                DONE: begin
                    if (drain_c) dbz <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.busy        = busy_q;
    assign bus.quotient    = q;
    assign bus.remainder   = r[VW-1:0];
    assign bus.div_by_zero = dbz;

endmodule

// File: tb/tb_seq_unsigned_divider.sv
// Self-checking bench for seq_unsigned_divider: directed corner cases, random
// operands against an arithmetic reference, stall, back-to-back and reset abort.
module tb_seq_unsigned_divider;
    localparam int unsigned DW = 16;
    localparam int unsigned VW = 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   cyc;

    seq_unsigned_divider_if #(.DW(DW), .VW(VW)) dif ();

    seq_unsigned_divider #(.DW(DW), .VW(VW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain integer division plus the expected result latency.
    function automatic void model(input logic [15:0] a, input logic [7:0] b,
                                  output logic [15:0] q, output logic [7:0] r,
                                  output logic z, output int lat);
        if (b == 8'd0) begin
            q = 16'hFFFF; r = 8'd0; z = 1'b1; lat = 1;
        end else begin
            q = 16'(a / b); r = 8'(a % b); z = 1'b0; lat = DW;
`ifdef DIV_EARLY_EXIT_EN
            if (a < 16'(b)) lat = 1;
`endif
        end
    endfunction

    // Offer operands, wait for the accept edge; returns positioned #1 after it.
    task automatic offer(input logic [15:0] a, input logic [7:0] b, output bit ok);
        int k;
        dif.dividend = a;
        dif.divisor  = b;
        dif.in_valid = 1'b1;
        k = 0;
        while (!dif.in_ready && k < 60) begin
            @(posedge clk); #1; k++;
        end
        ok = dif.in_ready;
        @(posedge clk); #1;
        dif.in_valid = 1'b0;
    endtask

    // Count edges after the accept edge until out_valid is seen.
    task automatic wait_result(output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!dif.out_valid && lat < 40);
    endtask

    // Complete one operation, check result and latency, then drain.
    task automatic run_op(input logic [15:0] a, input logic [7:0] b, input string name);
        logic [15:0] eq; logic [7:0] er; logic ez; int el; int lat; bit ok;
        model(a, b, eq, er, ez, el);
        dif.out_ready = 1'b0;
        offer(a, b, ok);
        n_checks++;
        if (!ok) begin
            n_errors++; $display("FAIL %s accept: in_ready never rose", name);
        end
        wait_result(lat);
        n_checks++;
        if (lat !== el) begin
            n_errors++; $display("FAIL %s latency: got %0d want %0d", name, lat, el);
        end
        n_checks++;
        if (dif.quotient !== eq || dif.remainder !== er || dif.div_by_zero !== ez) begin
            n_errors++;
            $display("FAIL %s result %0d/%0d: got q=%0d r=%0d z=%b want q=%0d r=%0d z=%b",
                     name, a, b, dif.quotient, dif.remainder, dif.div_by_zero, eq, er, ez);
        end
        if (b != 8'd0) begin
            n_checks++;
            if (32'(dif.quotient) * 32'(b) + 32'(dif.remainder) !== 32'(a) || dif.remainder >= b) begin
                n_errors++;
                $display("FAIL %s invariant %0d/%0d: got q=%0d r=%0d", name, a, b, dif.quotient, dif.remainder);
            end
        end
        dif.out_ready = 1'b1;
        @(posedge clk); #1;
        dif.out_ready = 1'b0;
        n_checks++;
        if (dif.out_valid !== 1'b0 || dif.in_ready !== 1'b1 || dif.busy !== 1'b0 || dif.div_by_zero !== 1'b0) begin
            n_errors++;
            $display("FAIL %s drain: got ov=%b ir=%b busy=%b z=%b want 0 1 0 0", name,
                     dif.out_valid, dif.in_ready, dif.busy, dif.div_by_zero);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0;
        n_checks++;
        if (dif.in_ready !== 1'b1 || dif.out_valid !== 1'b0 || dif.busy !== 1'b0 ||
            dif.quotient !== 16'd0 || dif.remainder !== 8'd0 || dif.div_by_zero !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state: got ir=%b ov=%b busy=%b q=%0d r=%0d z=%b want 1 0 0 0 0 0",
                     dif.in_ready, dif.out_valid, dif.busy, dif.quotient, dif.remainder, dif.div_by_zero);
        end
    endtask

    task automatic test_directed();
        run_op(16'd1000,  8'd7,   "d_1000_7");
        run_op(16'd65535, 8'd255, "d_65535_255");
        run_op(16'd65535, 8'd1,   "d_65535_1");
        run_op(16'd5,     8'd9,   "d_5_9");
        run_op(16'd1234,  8'd0,   "d_1234_0");
        run_op(16'd0,     8'd3,   "d_0_3");
        run_op(16'd255,   8'd255, "d_255_255");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [15:0] a; logic [7:0] b; int mode;
            mode = int'($urandom_range(0, 7));
            case (mode)
                0:       b = 8'd0;
                1:       b = 8'd1;
                2:       b = 8'd255;
                default: b = 8'($urandom_range(1, 255));
            endcase
            if ($urandom_range(0, 3) == 0) a = 16'($urandom_range(0, 300));
            else                           a = 16'($urandom);
            run_op(a, b, "rand");
        end
    endtask

    task automatic test_stall();
        logic [15:0] eq; logic [7:0] er; logic ez; int el; int lat; bit ok; int bad;
        model(16'd40000, 8'd123, eq, er, ez, el);
        dif.out_ready = 1'b0;
        offer(16'd40000, 8'd123, ok);
        wait_result(lat);
        n_checks++;
        if (lat !== el) begin
            n_errors++; $display("FAIL stall latency: got %0d want %0d", lat, el);
        end
        dif.dividend = 16'd77;
        dif.divisor  = 8'd0;
        dif.in_valid = 1'b1;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (dif.out_valid !== 1'b1 || dif.in_ready !== 1'b0 || dif.quotient !== eq ||
                dif.remainder !== er || dif.div_by_zero !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL stall hold: %0d unstable cycles, got q=%0d r=%0d ov=%b ir=%b want q=%0d r=%0d ov=1 ir=0",
                     bad, dif.quotient, dif.remainder, dif.out_valid, dif.in_ready, eq, er);
        end
        dif.in_valid  = 1'b0;
        dif.out_ready = 1'b1;
        @(posedge clk); #1;
        dif.out_ready = 1'b0;
        n_checks++;
        if (dif.out_valid !== 1'b0 || dif.in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL stall drain: got ov=%b ir=%b want 0 1", dif.out_valid, dif.in_ready);
        end
        run_op(16'd4321, 8'd17, "after_stall");
    endtask

    task automatic test_back_to_back();
        int acc [4]; int el_prev; int lat; bit ok;
        logic [15:0] a; logic [7:0] b; logic [15:0] eq; logic [7:0] er; logic ez; int el;
        dif.out_ready = 1'b1;
        el_prev = 0;
        for (int i = 0; i < 4; i++) begin
            a = 16'($urandom_range(256, 65535));
            b = 8'($urandom_range(1, 255));
            model(a, b, eq, er, ez, el);
            offer(a, b, ok);
            acc[i] = cyc;
            if (i > 0) begin
                n_checks++;
                if (acc[i] - acc[i-1] !== el_prev + 2) begin
                    n_errors++;
                    $display("FAIL b2b interval %0d: got %0d want %0d", i, acc[i] - acc[i-1], el_prev + 2);
                end
            end
            wait_result(lat);
            n_checks++;
            if (lat !== el || dif.quotient !== eq || dif.remainder !== er) begin
                n_errors++;
                $display("FAIL b2b result %0d/%0d: got q=%0d r=%0d lat=%0d want q=%0d r=%0d lat=%0d",
                         a, b, dif.quotient, dif.remainder, lat, eq, er, el);
            end
            el_prev = el;
        end
        @(posedge clk); #1;
        dif.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        bit ok; int seen;
        dif.out_ready = 1'b0;
        offer(16'd1000, 8'd7, ok);
        repeat (7) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        n_checks++;
        if (dif.in_ready !== 1'b1 || dif.out_valid !== 1'b0 || dif.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_reset state: got ir=%b ov=%b busy=%b want 1 0 0",
                     dif.in_ready, dif.out_valid, dif.busy);
        end
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (dif.out_valid) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_errors++; $display("FAIL mid_reset discard: got out_valid %0d cycles want 0", seen);
        end
        run_op(16'd300, 8'd20, "after_reset_300_20");
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        cyc           = 0;
        rst           = 1'b1;
        dif.in_valid  = 1'b0;
        dif.dividend  = '0;
        dif.divisor   = '0;
        dif.out_ready = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_stall();
        test_back_to_back();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
